// File: rtl/game_frame_sequencer_pkg.sv
// Shared definitions for the sine-wave game: phase encoding, screen geometry
// and the default animation/scroll constants that the scene logic also uses.
package game_pkg;

  typedef enum logic [1:0] {
    ST_INTRO = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CRASH = 2'd2,
    ST_WAIT  = 2'd3
  } game_state_t;

  localparam int SCREEN_WIDTH      = 640;
  localparam int SCREEN_HEIGHT     = 480;
  localparam int ANIM_LENGTH_DEF   = 110;
  localparam int SCROLL_PERIOD_DEF = 400;

  // 10-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/game_frame_sequencer_if.sv
// Sequencer <-> scene bundle: frame timing and collision in, game state out.
interface game_frame_sequencer_if;
  logic       vsync;
  logic       video_active;
  logic       hit;
  logic       btn_start;
  logic [9:0] animation;
  logic [9:0] x_offset;
  logic       game_started;
  logic       game_over;
  logic [9:0] score;

  modport master (
    input  vsync, video_active, hit, btn_start,
    output animation, x_offset, game_started, game_over, score
  );

  modport slave (
    output vsync, video_active, hit, btn_start,
    input  animation, x_offset, game_started, game_over, score
  );
endinterface

// File: rtl/game_frame_sequencer_rise_detect.sv
// Rising-edge detector with an optional SYNC-deep synchronizer in front;
// emits a single-cycle pulse per low-to-high transition.
module rise_detect #(
  parameter int SYNC = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic s;
  logic prev_q;

  generate
    if (SYNC > 0) begin : g_sync
      logic [SYNC-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d;
          for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC-1];
    end else begin : g_nosync
      assign s = d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= s;
  end

  assign pulse = s & ~prev_q;
endmodule

// File: rtl/game_frame_sequencer.sv
// Frame-synchronous game controller: intro box grow, scrolling play, crash hold
// and wait-for-restart, all advanced once per vsync rising edge.
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int ANIM_LENGTH      = ANIM_LENGTH_DEF,
  parameter int ANIM_STEP        = 3,
  parameter int SCROLL_PERIOD    = SCROLL_PERIOD_DEF,
  parameter int SCROLL_STEP_INIT = 4,
  parameter int SCROLL_STEP_MAX  = 8,
  parameter int SPEEDUP_FRAMES   = 256,
  parameter int CRASH_FRAMES     = 120
) (
  input logic             clk,
  input logic             reset,
  game_frame_sequencer_if.master gif
);
  localparam logic [10:0] ANIM_LEN_W  = 11'(ANIM_LENGTH);
  localparam logic [10:0] ANIM_STEP_W = 11'(ANIM_STEP);
  localparam logic [10:0] PERIOD_W    = 11'(SCROLL_PERIOD);
  localparam logic [9:0]  STEP_INIT_W = 10'(SCROLL_STEP_INIT);
  localparam logic [9:0]  STEP_MAX_W  = 10'(SCROLL_STEP_MAX);
  localparam logic [9:0]  SPEEDUP_W   = 10'(SPEEDUP_FRAMES);
  localparam logic [9:0]  CRASH_W     = 10'(CRASH_FRAMES);

  game_state_t state_q;
  logic [9:0]  anim_q, x_q, score_q, step_q, spd_q, crash_q;
  logic        started_q, over_q, hit_seen, press_pend;
  logic        tick, press;

  rise_detect #(.SYNC(0)) u_vsync_rise (.clk(clk), .reset(reset), .d(gif.vsync),     .pulse(tick));
  rise_detect #(.SYNC(2)) u_btn_rise   (.clk(clk), .reset(reset), .d(gif.btn_start), .pulse(press));

  logic [10:0] anim_sum, x_sum;
  logic [9:0]  anim_nxt, x_nxt, spd_nxt, crash_nxt, step_nxt;

  // Sums are one bit wider so the clamp/wrap compare never sees an overflow.
  always_comb begin
    anim_sum  = {1'b0, anim_q} + ANIM_STEP_W;
    anim_nxt  = (anim_sum >= ANIM_LEN_W) ? ANIM_LEN_W[9:0] : anim_sum[9:0];
    x_sum     = {1'b0, x_q} + {1'b0, step_q};
    x_nxt     = (x_sum >= PERIOD_W) ? 10'(x_sum - PERIOD_W) : x_sum[9:0];
    spd_nxt   = spd_q + 10'd1;
    crash_nxt = crash_q + 10'd1;
    step_nxt  = (step_q >= STEP_MAX_W) ? STEP_MAX_W : step_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INTRO;
      anim_q     <= '0;
      x_q        <= '0;
      score_q    <= '0;
      step_q     <= STEP_INIT_W;
      spd_q      <= '0;
      crash_q    <= '0;
      started_q  <= 1'b0;
      over_q     <= 1'b0;
      hit_seen   <= 1'b0;
      press_pend <= 1'b0;
    end else begin
      // Hit and press are gathered over the frame and consumed by the tick.
      if (tick)                               hit_seen <= 1'b0;
      else if (gif.hit && gif.video_active)   hit_seen <= 1'b1;
      if (tick)       press_pend <= 1'b0;
      else if (press) press_pend <= 1'b1;

      if (tick) begin
        unique case (state_q)
          ST_INTRO: begin
            anim_q <= anim_nxt;
            if (anim_nxt == ANIM_LEN_W[9:0]) begin
              state_q   <= ST_PLAY;
              started_q <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (hit_seen) begin
              state_q   <= ST_CRASH;
              started_q <= 1'b0;
              over_q    <= 1'b1;
            end else begin
              x_q     <= x_nxt;
              score_q <= sat_inc10(score_q);
              if (spd_nxt == SPEEDUP_W) begin
                spd_q  <= '0;
                step_q <= step_nxt;
              end else begin
                spd_q  <= spd_nxt;
              end
            end
          end
          ST_CRASH: begin
            crash_q <= crash_nxt;
            if (crash_nxt == CRASH_W) state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (press_pend) begin
              state_q <= ST_INTRO;
              anim_q  <= '0;
              x_q     <= '0;
              score_q <= '0;
              step_q  <= STEP_INIT_W;
              spd_q   <= '0;
              crash_q <= '0;
              over_q  <= 1'b0;
            end
          end
          default: state_q <= ST_INTRO;
        endcase
      end
    end
  end

  assign gif.animation    = anim_q;
  assign gif.x_offset     = x_q;
  assign gif.score        = score_q;
  assign gif.game_started = started_q;
  assign gif.game_over    = over_q;
endmodule
